// File: rtl/mha_bram_pkg.sv
// Shared types for the attention-pipeline BRAM path: tile shape, select layout, arbiter states.
package mha_bram_pkg;

  localparam int TILE_ROWS = 16;
  localparam int TILE_COLS = 128;
  localparam int TILE_DW   = 8;
  localparam int SEL_W     = 8;

  typedef logic [TILE_ROWS-1:0][TILE_COLS-1:0][TILE_DW-1:0] tile_t;

  // Matrix id lives in select bits [7:6]; [5:0] is the tile index.
  typedef enum logic [1:0] {
    MAT_Q = 2'b00,
    MAT_K = 2'b01,
    MAT_V = 2'b10,
    MAT_O = 2'b11
  } mat_id_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_ISSUE = 2'b01,
    S_WAIT  = 2'b10
  } arb_state_e;

endpackage

// File: rtl/bram_arbiter_rr_picker.sv
// Combinational round-robin search: first set request bit at or after the pointer, wrapping.
// Zero latency; no flow control of its own.
module rr_picker #(
  parameter  int N_REQ = 4,
  localparam int IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IW-1:0]    i_ptr,
  output logic [IW-1:0]    o_idx,
  output logic             o_found
);

  function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] p, input int off);
    int s;
    s = int'(p) + off;
    if (s >= N_REQ) s = s - N_REQ;
    return IW'(s);
  endfunction

  // Scan from the farthest offset down so the closest hit to the pointer is written last.
  always_comb begin
    o_idx   = '0;
    o_found = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (i_req[wrap_add(i_ptr, i)]) begin
        o_idx   = wrap_add(i_ptr, i);
        o_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bram_arbiter.sv
// Round-robin arbiter sharing one bram_manager between N_REQ tile requesters.
// Grant -> pulse next cycle -> ack on the matching done edge (or timeout); one transaction in flight.
module bram_arbiter #(
  parameter  int N_REQ   = 4,
  parameter  int ROWS    = 16,
  parameter  int COLS    = 128,
  parameter  int DW      = 8,
  parameter  int SEL_W   = 8,
  parameter  int TIMEOUT = 1024,
  localparam int IW      = $clog2(N_REQ),
  localparam int TW      = ROWS * COLS * DW
) (
  input  logic                        I_CLK,
  input  logic                        I_RST_N,
  input  logic [N_REQ-1:0]            I_REQ,
  input  logic [N_REQ-1:0]            I_REQ_WR,
  input  logic [N_REQ-1:0][SEL_W-1:0] I_REQ_SEL,
  input  logic [N_REQ-1:0][TW-1:0]    I_REQ_MAT,
  output logic [N_REQ-1:0]            O_ACK,
  output logic [TW-1:0]               O_RD_MAT,
  output logic [IW-1:0]               O_GNT_IDX,
  output logic                        O_BUSY,
  output logic                        O_ERR,
  output logic                        O_BRAM_RD_PULSE,
  output logic                        O_BRAM_WR_PULSE,
  output logic [SEL_W-1:0]            O_BRAM_SEL,
  output logic [TW-1:0]               O_BRAM_MAT,
  input  logic                        I_BRAM_VLD,
  input  logic [TW-1:0]               I_BRAM_MAT,
  input  logic                        I_BRAM_WR_DONE
);
  import mha_bram_pkg::*;

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  arb_state_e       r_state;
  logic [IW-1:0]    r_gnt;
  logic [IW-1:0]    r_ptr;
  logic             r_wr;
  logic [SEL_W-1:0] r_sel;
  logic             r_rd_pulse;
  logic             r_wr_pulse;
  logic             r_err;
  logic             r_prev_vld;
  logic             r_prev_wr_done;
  logic [CW-1:0]    r_cnt;

  logic [IW-1:0]    w_pick_idx;
  logic             w_pick_found;
  logic             w_edge;
  logic             w_timeout;
  logic             w_done;
  logic             w_busy;
  logic [IW-1:0]    w_ptr_next;

  rr_picker #(.N_REQ(N_REQ)) u_picker (
    .i_req   (I_REQ),
    .i_ptr   (r_ptr),
    .o_idx   (w_pick_idx),
    .o_found (w_pick_found)
  );

  // Only the done signal matching the granted direction can complete the transaction.
  assign w_edge     = r_wr ? (I_BRAM_WR_DONE & ~r_prev_wr_done) : (I_BRAM_VLD & ~r_prev_vld);
  assign w_timeout  = (r_cnt == CW'(TIMEOUT - 1));
  assign w_done     = (r_state == S_WAIT) && (w_edge || w_timeout);
  assign w_busy     = (r_state != S_IDLE);
  assign w_ptr_next = (r_gnt == IW'(N_REQ - 1)) ? '0 : r_gnt + 1'b1;

  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      r_state        <= S_IDLE;
      r_gnt          <= '0;
      r_ptr          <= '0;
      r_wr           <= 1'b0;
      r_sel          <= '0;
      r_rd_pulse     <= 1'b0;
      r_wr_pulse     <= 1'b0;
      r_err          <= 1'b0;
      r_prev_vld     <= 1'b0;
      r_prev_wr_done <= 1'b0;
      r_cnt          <= '0;
    end else begin
      r_prev_vld     <= I_BRAM_VLD;
      r_prev_wr_done <= I_BRAM_WR_DONE;
      r_rd_pulse     <= 1'b0;
      r_wr_pulse     <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_pick_found) begin
            r_gnt      <= w_pick_idx;
            r_wr       <= I_REQ_WR[w_pick_idx];
            r_sel      <= I_REQ_SEL[w_pick_idx];
            r_rd_pulse <= ~I_REQ_WR[w_pick_idx];
            r_wr_pulse <= I_REQ_WR[w_pick_idx];
            r_state    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_cnt   <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (w_done) begin
            if (!w_edge) r_err <= 1'b1;
            r_ptr   <= w_ptr_next;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    O_ACK = '0;
    if (w_done) O_ACK[r_gnt] = 1'b1;
  end

  assign O_RD_MAT        = (w_done && !r_wr) ? I_BRAM_MAT : '0;
  assign O_BRAM_MAT      = w_busy ? I_REQ_MAT[r_gnt] : '0;
  assign O_GNT_IDX       = r_gnt;
  assign O_BUSY          = w_busy;
  assign O_ERR           = r_err;
  assign O_BRAM_RD_PULSE = r_rd_pulse;
  assign O_BRAM_WR_PULSE = r_wr_pulse;
  assign O_BRAM_SEL      = r_sel;

endmodule

// File: tb/tb_bram_arbiter.sv
// Directed bench for bram_arbiter: table of single transactions plus hand-written corner sequences.
module tb_bram_arbiter;
  import mha_bram_pkg::*;

  localparam int TW = TILE_ROWS * TILE_COLS * TILE_DW;
  localparam int TO = 1024;

  logic              clk;
  logic              rst_n;
  logic [3:0]        req;
  logic [3:0]        req_wr;
  logic [3:0][7:0]   req_sel;
  logic [3:0][TW-1:0] req_mat;
  logic [3:0]        ack;
  logic [TW-1:0]     rd_mat;
  logic [1:0]        gnt_idx;
  logic              busy;
  logic              err;
  logic              rd_pulse;
  logic              wr_pulse;
  logic [7:0]        bram_sel;
  logic [TW-1:0]     bram_mat;
  logic              bram_vld;
  logic [TW-1:0]     bram_in_mat;
  logic              bram_wr_done;

  tile_t req_tile [4];

  int n_chk;
  int n_fail;

  typedef struct {
    logic [3:0] req;
    logic [3:0] wr;
    int         exp_gnt;
    int         delay;
    bit         noise;
    bit         drop;
  } vec_t;

  vec_t vecs [10];

  bram_arbiter dut (
    .I_CLK           (clk),
    .I_RST_N         (rst_n),
    .I_REQ           (req),
    .I_REQ_WR        (req_wr),
    .I_REQ_SEL       (req_sel),
    .I_REQ_MAT       (req_mat),
    .O_ACK           (ack),
    .O_RD_MAT        (rd_mat),
    .O_GNT_IDX       (gnt_idx),
    .O_BUSY          (busy),
    .O_ERR           (err),
    .O_BRAM_RD_PULSE (rd_pulse),
    .O_BRAM_WR_PULSE (wr_pulse),
    .O_BRAM_SEL      (bram_sel),
    .O_BRAM_MAT      (bram_mat),
    .I_BRAM_VLD      (bram_vld),
    .I_BRAM_MAT      (bram_in_mat),
    .I_BRAM_WR_DONE  (bram_wr_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: summary not reached within time limit");
    $fatal(1, "watchdog");
  end

  always_comb begin
    for (int i = 0; i < 4; i++) req_mat[i] = req_tile[i];
  end

  function automatic tile_t mk_tile(input logic [7:0] a, input logic [7:0] b,
                                    input logic [7:0] c, input logic [7:0] d);
    tile_t t;
    logic [7:0] v [4];
    v[0] = a; v[1] = b; v[2] = c; v[3] = d;
    for (int r = 0; r < TILE_ROWS; r++)
      for (int col = 0; col < TILE_COLS; col++)
        t[r][col] = v[r % 4];
    return t;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic chk_tile(input string name, input tile_t act, input tile_t exp);
    int pos;
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      pos = 0;
      for (int i = TW / 8 - 1; i >= 0; i--)
        if (act[i / TILE_COLS][i % TILE_COLS] !== exp[i / TILE_COLS][i % TILE_COLS]) pos = i;
      $display("FAIL %s: element %0d got %0h required %0h", name, pos,
               act[pos / TILE_COLS][pos % TILE_COLS], exp[pos / TILE_COLS][pos % TILE_COLS]);
    end
  endtask

  task automatic wait_pulse(output bit seen);
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      step();
      samp();
      if (rd_pulse || wr_pulse) begin
        seen = 1'b1;
        break;
      end
    end
    chk("pulse_seen", 64'(seen), 64'd1);
  endtask

  task automatic txn(input vec_t v, input tile_t rd_tile, output tile_t wr_cap);
    bit seen;
    bit ew;
    ew     = v.wr[v.exp_gnt];
    wr_cap = '0;
    step();
    req = v.req; req_wr = v.wr; bram_vld = 1'b0; bram_wr_done = 1'b0;
    samp();
    chk("idle_busy", 64'(busy), 64'd0);
    chk("idle_ack", 64'(ack), 64'd0);
    wait_pulse(seen);
    if (seen) begin
      chk("gnt_idx", 64'(gnt_idx), 64'(v.exp_gnt));
      chk("wr_pulse", 64'(wr_pulse), 64'(ew));
      chk("rd_pulse", 64'(rd_pulse), 64'(!ew));
      chk("bram_sel", 64'(bram_sel), 64'(req_sel[v.exp_gnt]));
      chk("issue_ack", 64'(ack), 64'd0);
      if (ew) chk_tile("wr_mat", bram_mat, req_tile[v.exp_gnt]);
      wr_cap = bram_mat;
      if (v.drop) req = '0;
      for (int d = 1; d < v.delay; d++) begin
        step();
        if (v.noise && d == 1) begin
          if (ew) bram_vld = 1'b1; else bram_wr_done = 1'b1;
        end else if (v.noise && d == 2) begin
          bram_vld = 1'b0; bram_wr_done = 1'b0;
        end
        samp();
        chk("wait_ack", 64'(ack), 64'd0);
        chk("wait_pulses", 64'({rd_pulse, wr_pulse}), 64'd0);
      end
      step();
      if (ew) bram_wr_done = 1'b1; else bram_vld = 1'b1;
      bram_in_mat = rd_tile;
      samp();
      chk("ack", 64'(4'b0001 << v.exp_gnt), 64'(ack) ^ 64'd0);
      if (!ew) chk_tile("rd_mat", rd_mat, rd_tile);
    end
  endtask

  initial begin
    bit    seen;
    int    cyc;
    bit    got;
    tile_t cap;
    tile_t wtile;
    vec_t  tv;

    n_chk = 0; n_fail = 0;
    rst_n = 1'b0; req = '0; req_wr = '0; bram_vld = 1'b0; bram_wr_done = 1'b0;
    bram_in_mat = '0;
    req_sel = {8'hC0, 8'h8A, 8'h45, 8'h00};
    for (int i = 0; i < 4; i++)
      req_tile[i] = mk_tile(8'(8'hA0 + i), 8'(8'hB0 + i), 8'(8'hC0 + i), 8'(8'hD0 + i));

    vecs[0] = '{4'b1111, 4'b0101, 0, 2, 1'b0, 1'b0};
    vecs[1] = '{4'b1111, 4'b0101, 1, 3, 1'b0, 1'b0};
    vecs[2] = '{4'b1111, 4'b0101, 2, 1, 1'b0, 1'b0};
    vecs[3] = '{4'b1111, 4'b0101, 3, 4, 1'b0, 1'b0};
    vecs[4] = '{4'b1111, 4'b0101, 0, 2, 1'b0, 1'b0};
    vecs[5] = '{4'b0010, 4'b0000, 1, 2, 1'b0, 1'b1};
    vecs[6] = '{4'b0011, 4'b0000, 0, 2, 1'b0, 1'b0};
    vecs[7] = '{4'b0001, 4'b0000, 0, 5, 1'b0, 1'b1};
    vecs[8] = '{4'b0100, 4'b0000, 2, 4, 1'b1, 1'b1};
    vecs[9] = '{4'b1000, 4'b1000, 3, 3, 1'b1, 1'b1};

    repeat (3) step();
    samp();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ack", 64'(ack), 64'd0);
    chk("rst_pulses", 64'({rd_pulse, wr_pulse}), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_gnt", 64'(gnt_idx), 64'd0);
    chk("rst_sel", 64'(bram_sel), 64'd0);
    step();
    rst_n = 1'b1;
    samp();
    chk("post_rst_busy", 64'(busy), 64'd0);

    for (int i = 0; i < 10; i++)
      txn(vecs[i], mk_tile(8'(8'h10 + i), 8'(8'h20 + i), 8'(8'h30 + i), 8'(8'h40 + i)), cap);

    // Write a tile to sel C0, then read it back from a bram model holding what was written.
    req_tile[3] = mk_tile(8'h55, 8'h66, 8'h77, 8'h88);
    wtile = '0;
    tv = '{4'b1000, 4'b1000, 3, 2, 1'b0, 1'b1};
    txn(tv, wtile, cap);
    tv = '{4'b1000, 4'b0000, 3, 3, 1'b0, 1'b1};
    txn(tv, cap, wtile);
    chk_tile("rd_back", rd_mat, mk_tile(8'h55, 8'h66, 8'h77, 8'h88));

    // VLD already high before ISSUE must not complete the read.
    step();
    req = 4'b0001; req_wr = 4'b0000; bram_vld = 1'b1; bram_wr_done = 1'b0;
    samp();
    wait_pulse(seen);
    chk("held_gnt", 64'(gnt_idx), 64'd0);
    req = '0;
    for (int k = 0; k < 3; k++) begin
      step(); samp();
      chk("held_no_ack", 64'(ack), 64'd0);
    end
    step(); bram_vld = 1'b0; samp();
    chk("held_low_no_ack", 64'(ack), 64'd0);
    step(); bram_vld = 1'b1; samp();
    chk("held_fresh_ack", 64'(ack), 64'b0001);

    // Timeout: read with no VLD edge ever.
    step();
    req = 4'b0100; req_wr = 4'b0000; bram_vld = 1'b0; bram_wr_done = 1'b0;
    samp();
    wait_pulse(seen);
    req = '0;
    cyc = 0; got = 1'b0;
    while (cyc < TO + 8 && !got) begin
      step(); samp();
      cyc++;
      if (ack != 4'b0000) got = 1'b1;
    end
    chk("timeout_cycles", 64'(cyc), 64'(TO));
    chk("timeout_ack", 64'(ack), 64'b0100);
    step(); samp();
    chk("timeout_err", 64'(err), 64'd1);
    chk("timeout_idle", 64'(busy), 64'd0);
    tv = '{4'b0010, 4'b0000, 1, 2, 1'b0, 1'b1};
    txn(tv, mk_tile(8'h01, 8'h02, 8'h03, 8'h04), cap);
    chk("err_sticky", 64'(err), 64'd1);

    // Reset in the middle of WAIT.
    step();
    req = 4'b0100; req_wr = 4'b0000; bram_vld = 1'b0; bram_wr_done = 1'b0;
    samp();
    wait_pulse(seen);
    step(); req = '0; samp();
    chk("mid_busy", 64'(busy), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("mrst_busy", 64'(busy), 64'd0);
    chk("mrst_ack", 64'(ack), 64'd0);
    chk("mrst_pulses", 64'({rd_pulse, wr_pulse}), 64'd0);
    chk("mrst_err", 64'(err), 64'd0);
    chk("mrst_gnt", 64'(gnt_idx), 64'd0);
    chk("mrst_sel", 64'(bram_sel), 64'd0);
    chk_tile("mrst_bram_mat", bram_mat, '0);
    chk_tile("mrst_rd_mat", rd_mat, '0);
    bram_vld = 1'b1;
    step(); samp();
    chk("mrst_vld_no_ack", 64'(ack), 64'd0);
    req = 4'b1010; bram_vld = 1'b0;
    step(); rst_n = 1'b1; samp();
    chk("rel_busy", 64'(busy), 64'd0);
    wait_pulse(seen);
    chk("rel_gnt", 64'(gnt_idx), 64'd1);
    chk("rel_rd_pulse", 64'(rd_pulse), 64'd1);
    req = '0;
    step(); bram_vld = 1'b1; samp();
    chk("rel_ack", 64'(ack), 64'b0010);
    step(); bram_vld = 1'b0; samp();
    chk("rel_ack_done", 64'(ack), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
